// File: rtl/id_operand_scoreboard.sv
// id_operand_scoreboard: decode-stage operand resolution with a per-register
// busy scoreboard for outstanding variable-latency loads, hazard stall
// generation, and the ID/EX pipeline register.
module id_operand_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NFWD   = 2,
  parameter int MAX_LD = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dec_valid,
  input  logic [4:0]                    dec_rs1_addr,
  input  logic [4:0]                    dec_rs2_addr,
  input  logic [4:0]                    dec_rd_addr,
  input  logic                          dec_rs1_en,
  input  logic                          dec_rs2_en,
  input  logic                          dec_rd_en,
  input  logic                          dec_is_load,
  input  logic                          dec_alusrc,
  input  logic [XLEN-1:0]               dec_imm,
  input  logic [XLEN-1:0]               rf_rs1_data,
  input  logic [XLEN-1:0]               rf_rs2_data,
  input  logic [NFWD-1:0]               fwd_en,
  input  logic [5*NFWD-1:0]             fwd_addr,
  input  logic [XLEN*NFWD-1:0]          fwd_data,
  input  logic                          ld_wb_en,
  input  logic [4:0]                    ld_wb_addr,
  input  logic [XLEN-1:0]               ld_wb_data,
  input  logic                          ex_stall,
  input  logic                          flush,
  output logic                          stall_req,
  output logic                          ex_valid,
  output logic [XLEN-1:0]               ex_op1,
  output logic [XLEN-1:0]               ex_op2,
  output logic [XLEN-1:0]               ex_store_data,
  output logic [4:0]                    ex_rd_addr,
  output logic                          ex_rd_en,
  output logic                          ex_is_load,
  output logic [$clog2(MAX_LD+1)-1:0]   ld_outstanding
);

  localparam int CW = $clog2(MAX_LD + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Resolve one source operand; returns {hazard, data}. Inside the busy
  // branch an address match on the load port is by definition a clear.
  function automatic logic [XLEN:0] resolve_src(
    input logic                 en,
    input logic [4:0]           addr,
    input logic [XLEN-1:0]      rf_data,
    input logic [31:0]          busy,
    input logic [NFWD-1:0]      f_en,
    input logic [5*NFWD-1:0]    f_addr,
    input logic [XLEN*NFWD-1:0] f_data,
    input logic                 wb_en,
    input logic [4:0]           wb_addr,
    input logic [XLEN-1:0]      wb_data
  );
    logic [XLEN-1:0] data;
    logic            haz;
    data = '0;
    haz  = 1'b0;
    if (!en || (addr == 5'd0)) begin
      data = '0;
    end else if (busy[addr]) begin
      if (wb_en && (wb_addr == addr)) begin
        data = wb_data;
      end else begin
        haz = 1'b1;
      end
    end else begin
      data = (wb_en && (wb_addr == addr)) ? wb_data : rf_data;
      // Walk from the oldest port down so the youngest match is applied last.
      for (int i = NFWD - 1; i >= 0; i--) begin
        data = (f_en[i] && (f_addr[5*i +: 5] == addr)) ? f_data[XLEN*i +: XLEN] : data;
      end
    end
    return {haz, data};
  endfunction

  logic [31:0]     busy_r;
  logic [CW-1:0]   cnt_r;
  logic [31:0]     clr_vec_s;
  logic [31:0]     set_vec_s;
  logic [31:0]     busy_nxt_s;
  logic [CW-1:0]   cnt_nxt_s;
  logic [XLEN:0]   rs1_res_s;
  logic [XLEN:0]   rs2_res_s;
  logic [XLEN-1:0] op1_s;
  logic [XLEN-1:0] rs2_val_s;
  logic [XLEN-1:0] op2_s;
  logic            any_clr_s;
  logic            waw_s;
  logic            ld_full_s;
  logic            hazard_s;
  logic            fire_s;
  logic            set_s;

  // Per-register load-return clear strobes; x0 never clears.
  always_comb begin
    clr_vec_s = 32'd0;
    for (int r = 1; r < 32; r++) begin
      clr_vec_s[r] = ld_wb_en && (ld_wb_addr == 5'(r)) && busy_r[r];
    end
  end

  // Operand resolution, hazard detection and issue decision.
  always_comb begin
    rs1_res_s = resolve_src(dec_rs1_en, dec_rs1_addr, rf_rs1_data, busy_r, fwd_en,
                            fwd_addr, fwd_data, ld_wb_en, ld_wb_addr, ld_wb_data);
    rs2_res_s = resolve_src(dec_rs2_en, dec_rs2_addr, rf_rs2_data, busy_r, fwd_en,
                            fwd_addr, fwd_data, ld_wb_en, ld_wb_addr, ld_wb_data);
    op1_s     = rs1_res_s[XLEN-1:0];
    rs2_val_s = rs2_res_s[XLEN-1:0];
    op2_s     = dec_alusrc ? dec_imm : rs2_val_s;
    any_clr_s = |clr_vec_s;
    waw_s     = dec_rd_en && (dec_rd_addr != 5'd0) && busy_r[dec_rd_addr]
                && !clr_vec_s[dec_rd_addr];
    ld_full_s = dec_is_load && (cnt_r == MAX_CNT) && !any_clr_s;
    hazard_s  = rs1_res_s[XLEN] || rs2_res_s[XLEN] || waw_s || ld_full_s;
    stall_req = rst && dec_valid && hazard_s;
    fire_s    = dec_valid && !stall_req && !ex_stall && !flush;
    set_s     = fire_s && dec_is_load && dec_rd_en && (dec_rd_addr != 5'd0);
  end

  // Next scoreboard state: a set in the same cycle as a clear of that register wins.
  always_comb begin
    set_vec_s  = set_s ? (32'd1 << dec_rd_addr) : 32'd0;
    busy_nxt_s = (busy_r & ~clr_vec_s) | set_vec_s;
    case ({set_s, any_clr_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Scoreboard registers; reset discards every outstanding load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= 32'd0;
      cnt_r  <= '0;
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign ld_outstanding = cnt_r;

  // ID/EX pipeline register: flush beats ex_stall, which beats a new issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid      <= 1'b0;
      ex_op1        <= '0;
      ex_op2        <= '0;
      ex_store_data <= '0;
      ex_rd_addr    <= 5'd0;
      ex_rd_en      <= 1'b0;
      ex_is_load    <= 1'b0;
    end else if (flush) begin
      ex_valid      <= 1'b0;
      ex_op1        <= '0;
      ex_op2        <= '0;
      ex_store_data <= '0;
      ex_rd_addr    <= 5'd0;
      ex_rd_en      <= 1'b0;
      ex_is_load    <= 1'b0;
    end else if (ex_stall) begin
      ex_valid      <= ex_valid;
    end else begin
      ex_valid <= fire_s;
      if (fire_s) begin
        ex_op1        <= op1_s;
        ex_op2        <= op2_s;
        ex_store_data <= rs2_val_s;
        ex_rd_addr    <= dec_rd_addr;
        ex_rd_en      <= dec_rd_en;
        ex_is_load    <= dec_is_load;
      end else begin
        ex_op1        <= ex_op1;
      end
    end
  end

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Self-checking bench for id_operand_scoreboard: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_id_operand_scoreboard;

  localparam int XLEN   = 32;
  localparam int NFWD   = 2;
  localparam int MAX_LD = 4;

  logic clk = 1'b0;
  logic rst;
  logic dec_valid;
  logic [4:0] dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic dec_rs1_en, dec_rs2_en, dec_rd_en, dec_is_load, dec_alusrc;
  logic [XLEN-1:0] dec_imm, rf_rs1_data, rf_rs2_data;
  logic [NFWD-1:0] fwd_en;
  logic [5*NFWD-1:0] fwd_addr;
  logic [XLEN*NFWD-1:0] fwd_data;
  logic ld_wb_en;
  logic [4:0] ld_wb_addr;
  logic [XLEN-1:0] ld_wb_data;
  logic ex_stall, flush;
  logic stall_req, ex_valid, ex_rd_en, ex_is_load;
  logic [XLEN-1:0] ex_op1, ex_op2, ex_store_data;
  logic [4:0] ex_rd_addr;
  logic [2:0] ld_outstanding;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit m_busy [32];
  int m_cnt;
  logic m_v, m_rden, m_isld;
  logic [31:0] m_op1, m_op2, m_sd;
  logic [4:0] m_rd;

  id_operand_scoreboard #(.XLEN(XLEN), .NFWD(NFWD), .MAX_LD(MAX_LD)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd_addr(dec_rd_addr),
    .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en), .dec_rd_en(dec_rd_en),
    .dec_is_load(dec_is_load), .dec_alusrc(dec_alusrc), .dec_imm(dec_imm),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .ld_wb_en(ld_wb_en), .ld_wb_addr(ld_wb_addr), .ld_wb_data(ld_wb_data),
    .ex_stall(ex_stall), .flush(flush), .stall_req(stall_req), .ex_valid(ex_valid),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_rd_en(ex_rd_en), .ex_is_load(ex_is_load),
    .ld_outstanding(ld_outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_cnt = 0; m_v = 1'b0; m_op1 = '0; m_op2 = '0; m_sd = '0;
    m_rd = '0; m_rden = 1'b0; m_isld = 1'b0;
  endtask

  // Value an instruction sees for one source, or a hazard if it must wait.
  task automatic model_src(input logic en, input logic [4:0] a, input logic [31:0] rf,
                           output logic [31:0] d, output bit h);
    bit found;
    d = 32'd0; h = 1'b0; found = 1'b0;
    if (en && a != 5'd0) begin
      if (m_busy[a]) begin
        if (ld_wb_en && ld_wb_addr == a) d = ld_wb_data;
        else h = 1'b1;
      end else begin
        for (int i = 0; i < NFWD; i++) begin
          if (!found && fwd_en[i] && fwd_addr[5*i +: 5] == a) begin
            d = fwd_data[XLEN*i +: XLEN];
            found = 1'b1;
          end
        end
        if (!found) d = (ld_wb_en && ld_wb_addr == a) ? ld_wb_data : rf;
      end
    end
  endtask

  // One clock: check the combinational stall, advance the model, check registered state.
  task automatic tick(input string tag);
    logic [31:0] d1, d2;
    bit h1, h2, waw, full, anyc, exp_stall, fire;
    #3;
    model_src(dec_rs1_en, dec_rs1_addr, rf_rs1_data, d1, h1);
    model_src(dec_rs2_en, dec_rs2_addr, rf_rs2_data, d2, h2);
    anyc = ld_wb_en && ld_wb_addr != 5'd0 && m_busy[ld_wb_addr];
    waw  = dec_rd_en && dec_rd_addr != 5'd0 && m_busy[dec_rd_addr]
           && !(ld_wb_en && ld_wb_addr == dec_rd_addr);
    full = dec_is_load && m_cnt == MAX_LD && !anyc;
    exp_stall = dec_valid && (h1 || h2 || waw || full);
    chk({tag, "_stall_req"}, {31'd0, stall_req}, {31'd0, exp_stall});
    fire = dec_valid && !exp_stall && !ex_stall && !flush;
    if (flush) m_v = 1'b0;
    else if (!ex_stall) begin
      m_v = fire;
      if (fire) begin
        m_op1 = d1; m_op2 = dec_alusrc ? dec_imm : d2; m_sd = d2;
        m_rd = dec_rd_addr; m_rden = dec_rd_en; m_isld = dec_is_load;
      end
    end
    if (anyc) begin m_busy[ld_wb_addr] = 1'b0; m_cnt--; end
    if (fire && dec_is_load && dec_rd_en && dec_rd_addr != 5'd0) begin
      m_busy[dec_rd_addr] = 1'b1; m_cnt++;
    end
    @(posedge clk); #1;
    chk({tag, "_ex_valid"}, {31'd0, ex_valid}, {31'd0, m_v});
    chk({tag, "_ld_outstanding"}, {29'd0, ld_outstanding}, 32'(m_cnt));
    chk({tag, "_busy"}, dut.busy_r, model_busy_vec());
    if (m_v) begin
      chk({tag, "_ex_op1"}, ex_op1, m_op1);
      chk({tag, "_ex_op2"}, ex_op2, m_op2);
      chk({tag, "_ex_store_data"}, ex_store_data, m_sd);
      chk({tag, "_ex_rd"}, {25'd0, ex_rd_en, ex_is_load, ex_rd_addr}, {25'd0, m_rden, m_isld, m_rd});
    end
  endtask

  task automatic clr_in();
    dec_valid = 0; dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rd_addr = 0;
    dec_rs1_en = 0; dec_rs2_en = 0; dec_rd_en = 0; dec_is_load = 0; dec_alusrc = 0;
    dec_imm = 0; rf_rs1_data = 0; rf_rs2_data = 0; fwd_en = 0; fwd_addr = 0; fwd_data = 0;
    ld_wb_en = 0; ld_wb_addr = 0; ld_wb_data = 0; ex_stall = 0; flush = 0;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic rs1en, input logic [4:0] rs2,
                     input logic rs2en, input logic [4:0] rd, input logic rden,
                     input logic ld, input logic asrc, input logic [31:0] imm);
    dec_valid = 1; dec_rs1_addr = rs1; dec_rs1_en = rs1en; dec_rs2_addr = rs2;
    dec_rs2_en = rs2en; dec_rd_addr = rd; dec_rd_en = rden; dec_is_load = ld;
    dec_alusrc = asrc; dec_imm = imm;
  endtask

  initial begin
    int q[$];
    clr_in();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    dec_valid = 1; dec_is_load = 1; dec_rd_en = 1; dec_rd_addr = 5'd3;
    #1;
    chk("reset_stall_req", {31'd0, stall_req}, 32'd0);
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_ex_op1", ex_op1, 32'd0);
    chk("reset_cnt", {29'd0, ld_outstanding}, 32'd0);
    clr_in();
    @(posedge clk); #1;
    rst = 1'b1;

    // Forwarding priority: port 0 beats port 1 and the register file.
    dec(5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 32'd0);
    fwd_en = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'h22, 32'h11}; rf_rs1_data = 32'h33;
    tick("fwd");
    chk("fwd_prio_op1", ex_op1, 32'h11);

    // Load-use across a delayed return.
    clr_in();
    dec(5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 1, 32'd4); rf_rs1_data = 32'h100;
    tick("lu_load");
    dec(5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 32'd0); dec_is_load = 0; dec_alusrc = 0;
    rf_rs1_data = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      tick("lu_wait");
      chk("lu_stall_held", {31'd0, stall_req}, 32'd1);
      chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    end
    ld_wb_en = 1; ld_wb_addr = 5'd7; ld_wb_data = 32'hDEAD;
    tick("lu_ret");
    chk("lu_op1", ex_op1, 32'hDEAD);
    chk("lu_issue", {31'd0, ex_valid}, 32'd1);
    chk("lu_busy7", {31'd0, dut.busy_r[7]}, 32'd0);

    // x0 immunity.
    clr_in();
    dec(5'd0, 1, 5'd0, 1, 5'd0, 1, 1, 0, 32'd0);
    rf_rs1_data = 32'hFFFF; rf_rs2_data = 32'hFFFF; fwd_en = 2'b01; fwd_data = {32'h0, 32'h55};
    tick("x0");
    chk("x0_op1", ex_op1, 32'd0);
    chk("x0_sd", ex_store_data, 32'd0);
    chk("x0_cnt", {29'd0, ld_outstanding}, 32'd0);

    // Outstanding limit.
    clr_in();
    for (int i = 1; i <= 4; i++) begin
      dec(5'd0, 0, 5'd0, 0, 5'(i), 1, 1, 1, 32'(i));
      tick("lim_fill");
    end
    chk("lim_cnt4", {29'd0, ld_outstanding}, 32'd4);
    dec(5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 1, 32'd5);
    tick("lim_5th");
    chk("lim_stall", {31'd0, stall_req}, 32'd1);
    chk("lim_bubble", {31'd0, ex_valid}, 32'd0);
    ld_wb_en = 1; ld_wb_addr = 5'd2; ld_wb_data = 32'h2222;
    tick("lim_ret");
    chk("lim_fire", {31'd0, ex_valid}, 32'd1);
    chk("lim_cnt_kept", {29'd0, ld_outstanding}, 32'd4);
    chk("lim_busy", dut.busy_r, 32'h3A);

    // ex_stall hold, then flush with ex_stall.
    clr_in();
    dec(5'd9, 1, 5'd0, 0, 5'd10, 1, 0, 1, 32'h10); rf_rs1_data = 32'hABC;
    tick("hold_issue");
    chk("hold_op1_live", ex_op1, 32'hABC);
    ex_stall = 1;
    dec(5'd11, 1, 5'd0, 0, 5'd12, 1, 0, 0, 32'd0); rf_rs1_data = 32'h999;
    tick("hold");
    chk("hold_op1", ex_op1, 32'hABC);
    chk("hold_rd", {27'd0, ex_rd_addr}, 32'd10);
    flush = 1;
    tick("flush");
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_busy", dut.busy_r, 32'h3A);

    // Reset in the middle of operation with two loads outstanding.
    clr_in();
    ld_wb_en = 1; ld_wb_addr = 5'd1; ld_wb_data = 32'h1;
    tick("mr_ret1");
    ld_wb_addr = 5'd3;
    tick("mr_ret3");
    clr_in();
    dec(5'd20, 1, 5'd0, 0, 5'd21, 1, 0, 1, 32'h77); rf_rs1_data = 32'h1234;
    tick("mr_alu");
    chk("mr_cnt2", {29'd0, ld_outstanding}, 32'd2);
    clr_in();
    #2 rst = 1'b0;
    #1;
    chk("mr_cnt", {29'd0, ld_outstanding}, 32'd0);
    chk("mr_busy", dut.busy_r, 32'd0);
    chk("mr_valid", {31'd0, ex_valid}, 32'd0);
    chk("mr_op", ex_op1 | ex_op2 | ex_store_data, 32'd0);
    chk("mr_rd", {25'd0, ex_rd_en, ex_is_load, ex_rd_addr}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 500; n++) begin
      dec_valid    = ($urandom_range(0, 9) < 8);
      dec_rs1_addr = 5'($urandom_range(0, 7));
      dec_rs2_addr = 5'($urandom_range(0, 7));
      dec_rd_addr  = 5'($urandom_range(0, 7));
      dec_rs1_en   = 1'($urandom_range(0, 1));
      dec_rs2_en   = 1'($urandom_range(0, 1));
      dec_rd_en    = ($urandom_range(0, 3) != 0);
      dec_is_load  = ($urandom_range(0, 9) < 4);
      dec_alusrc   = 1'($urandom_range(0, 1));
      dec_imm      = $urandom;
      rf_rs1_data  = $urandom;
      rf_rs2_data  = $urandom;
      fwd_en       = 2'($urandom_range(0, 3));
      fwd_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_data     = {$urandom, $urandom};
      ld_wb_en     = ($urandom_range(0, 9) < 4);
      ld_wb_data   = $urandom;
      ld_wb_addr   = 5'($urandom_range(0, 7));
      q.delete();
      for (int r = 1; r < 8; r++) if (m_busy[r]) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        ld_wb_addr = 5'(q[$urandom_range(0, q.size() - 1)]);
      ex_stall     = ($urandom_range(0, 99) < 15);
      flush        = ($urandom_range(0, 99) < 5);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
